// File: rtl/sw_scoring_module.sv
// Smith-Waterman affine-gap local-alignment scorer: LENGTH-PE systolic array, query held one base per PE.
// Latency: result/vld registered LENGTH+1 cycles after the edge that samples a sequence's last base.
// Backpressure: none; one base accepted per cycle, sequences separated by at least one idle cycle.
// Build option SW_SCORE_SAT_EN: scores saturate at 2**SCORE_WIDTH-1 (undefined: upper bound wraps).
module sw_scoring_module #(
   parameter int         SCORE_WIDTH = 12,
   parameter int         LENGTH      = 48,
   parameter int         LOG_LENGTH  = $clog2(LENGTH),
   parameter logic [1:0] _A          = 2'b00,
   parameter logic [1:0] _G          = 2'b01,
   parameter logic [1:0] _T          = 2'b10,
   parameter logic [1:0] _C          = 2'b11,
   parameter int         ZERO        = 2**(SCORE_WIDTH-1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en_in,
   input  logic [1:0]                    data_in,
   input  logic [2*LENGTH-1:0]           query,
   input  logic signed [SCORE_WIDTH-1:0] match,
   input  logic signed [SCORE_WIDTH-1:0] mismatch,
   input  logic signed [SCORE_WIDTH-1:0] gap_open,
   input  logic signed [SCORE_WIDTH-1:0] gap_extend,
   input  logic [11:0]                   counter_in,
   output logic [SCORE_WIDTH-1:0]        result,
   output logic                          vld
);

   localparam int SW = SCORE_WIDTH;
   localparam int WW = SCORE_WIDTH + 2;
   localparam logic [SW-1:0] ZV = SW'(ZERO);

   // Everything one PE hands to the next, registered once per PE.
   typedef struct packed {
      logic [1:0]    base;
      logic          en;
      logic          first;
      logic [SW-1:0] h;     // H of this base in the previous row (H_left for next PE)
      logic [SW-1:0] hd;    // H of the previous base in the previous row (H_diag)
      logic [SW-1:0] e;     // E travelling along the query
      logic [SW-1:0] high;  // best score seen so far for this sequence
   } stage_t;

   localparam stage_t STAGE_RST = '{base: 2'b00, en: 1'b0, first: 1'b0,
                                    h: ZV, hd: ZV, e: ZV, high: ZV};

   function automatic logic signed [WW-1:0] ext(input logic [SW-1:0] v);
      return $signed({2'b00, v});
   endfunction

   function automatic logic signed [WW-1:0] smax(input logic signed [WW-1:0] a,
                                                 input logic signed [WW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Biased scores never drop below ZERO; the top either saturates or wraps.
   function automatic logic [SW-1:0] clamp(input logic signed [WW-1:0] x);
      logic [SW-1:0] r;
      if (x < ext(ZV))
         r = ZV;
`ifdef SW_SCORE_SAT_EN
      else if (x > ext({SW{1'b1}}))
         r = {SW{1'b1}};
`endif
      else
         r = x[SW-1:0];
      return r;
   endfunction

   // Maps incoming codes onto the named alphabet; bases are compared as raw codes.
   function automatic logic [1:0] canon(input logic [1:0] b);
      logic [1:0] r;
      case (b)
         _A:      r = _A;
         _G:      r = _G;
         _T:      r = _T;
         default: r = _C;
      endcase
      return r;
   endfunction

   logic signed [WW-1:0] w_match_x, w_mismatch_x, w_go_x, w_ge_x;
   assign w_match_x    = {{2{match[SW-1]}}, match};
   assign w_mismatch_x = {{2{mismatch[SW-1]}}, mismatch};
   assign w_go_x       = {{2{gap_open[SW-1]}}, gap_open};
   assign w_ge_x       = {{2{gap_extend[SW-1]}}, gap_extend};

   // Active query length, capped at the number of PEs.
   logic [LOG_LENGTH:0] w_qlen;
   assign w_qlen = (counter_in >= 12'(LENGTH)) ? (LOG_LENGTH+1)'(LENGTH)
                                               : counter_in[LOG_LENGTH:0];

   stage_t w_stage [0:LENGTH];
   stage_t w_in0;
   logic   r_en_prev;

   // Array entry: row-0 boundary scores are ZERO; first flag marks a rising en_in.
   always_comb begin
      w_in0       = STAGE_RST;
      w_in0.base  = canon(data_in);
      w_in0.en    = en_in;
      w_in0.first = en_in & ~r_en_prev;
   end
   assign w_stage[0] = w_in0;

   for (genvar k = 0; k < LENGTH; k++) begin : g_pe
      stage_t               w_in;
      stage_t               r_out;
      logic [SW-1:0]        r_h, r_f, r_hi;
      logic [SW-1:0]        w_hup, w_fup, w_hi_prev, w_e, w_f, w_h, w_high;
      logic signed [WW-1:0] w_s;
      logic                 w_act;

      assign w_in  = w_stage[k];
      assign w_act = ((LOG_LENGTH+1)'(k) < w_qlen);

      // Cell recurrences; column state restarts at ZERO on a sequence's first base.
      always_comb begin
         w_hup     = w_in.first ? ZV : r_h;
         w_fup     = w_in.first ? ZV : r_f;
         w_hi_prev = w_in.first ? ZV : r_hi;
         w_s       = (w_in.base == query[2*k +: 2]) ? w_match_x : w_mismatch_x;
         w_e       = clamp(smax(ext(w_in.h) + w_go_x, ext(w_in.e) + w_ge_x));
         w_f       = clamp(smax(ext(w_hup) + w_go_x, ext(w_fup) + w_ge_x));
         w_h       = clamp(smax(smax(ext(w_in.hd) + w_s, ext(w_e)), ext(w_f)));
         w_high    = w_h;
         if (w_hi_prev > w_high) w_high = w_hi_prev;
         if (w_in.high > w_high) w_high = w_in.high;
      end

      // PE state and forwarding register; a bypassed PE passes scores through untouched.
      always_ff @(posedge clk) begin
         if (!rst) begin
            r_h   <= ZV;
            r_f   <= ZV;
            r_hi  <= ZV;
            r_out <= STAGE_RST;
         end else begin
            r_out.base  <= w_in.base;
            r_out.en    <= w_in.en;
            r_out.first <= w_in.first;
            if (w_act && w_in.en) begin
               r_h        <= w_h;
               r_f        <= w_f;
               r_hi       <= w_high;
               r_out.h    <= w_h;
               r_out.hd   <= w_hup;
               r_out.e    <= w_e;
               r_out.high <= w_high;
            end else begin
               r_out.h    <= w_in.h;
               r_out.hd   <= w_in.hd;
               r_out.e    <= w_in.e;
               r_out.high <= w_in.high;
            end
         end
      end

      assign w_stage[k+1] = r_out;
   end

   logic          r_en_d;
   logic [SW-1:0] r_hi_d;
   logic [SW-1:0] r_result;
   logic          r_vld;

   // Output: the falling edge of the enable at the array tail marks the last base.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_en_prev <= 1'b0;
         r_en_d    <= 1'b0;
         r_hi_d    <= ZV;
         r_vld     <= 1'b0;
         r_result  <= ZV;
      end else begin
         r_en_prev <= en_in;
         r_en_d    <= w_stage[LENGTH].en;
         r_hi_d    <= w_stage[LENGTH].high;
         r_vld     <= r_en_d & ~w_stage[LENGTH].en;
         if (r_en_d && !w_stage[LENGTH].en)
            r_result <= r_hi_d;
      end
   end

   assign result = r_result;
   assign vld    = r_vld;

endmodule

// File: tb/tb_sw_scoring_module.sv
// Bench for sw_scoring_module: table of sequences scored against a dynamic-programming reference.
// Latency: every expected result carries the cycle at which vld must appear.
// Backpressure: none in the DUT; the bench drains its scoreboard between table entries.
module tb_sw_scoring_module;
   localparam int SW     = 12;
   localparam int LENGTH = 48;
   localparam int ZERO   = 2**(SW-1);
   localparam int MAXV   = 2**SW - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en_in;
   logic [1:0]           data_in;
   logic [2*LENGTH-1:0]  query;
   logic signed [SW-1:0] t_match, t_mismatch, t_gap_open, t_gap_extend;
   logic [11:0]          counter_in;
   logic [SW-1:0]        result;
   logic                 vld;

   typedef struct {
      string name;
      string q;
      int    cnt;
      string db;
      int    m;
      int    mm;
      int    go;
      int    ge;
      int    exp;   // biased expected result, or -1 to use the reference model
   } vec_t;

   typedef struct {
      string name;
      int    exp;
      int    cyc;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];
   int   vld_hist[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   sw_scoring_module #(.SCORE_WIDTH(SW), .LENGTH(LENGTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_in      (en_in),
      .data_in    (data_in),
      .query      (query),
      .match      (t_match),
      .mismatch   (t_mismatch),
      .gap_open   (t_gap_open),
      .gap_extend (t_gap_extend),
      .counter_in (counter_in),
      .result     (result),
      .vld        (vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   function automatic logic [1:0] code(input byte c);
      case (c)
         "A":     return 2'b00;
         "G":     return 2'b01;
         "T":     return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   function automatic string rep(input string c, input int n);
      string s = "";
      for (int i = 0; i < n; i++) s = {s, c};
      return s;
   endfunction

   function automatic int mx(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cl(input int x);
      if (x < ZERO) return ZERO;
`ifdef SW_SCORE_SAT_EN
      if (x > MAXV) return MAXV;
`endif
      return x & MAXV;
   endfunction

   // Full DP matrix over (query row i, database column j), biased by ZERO.
   function automatic int model(input string q, input int cnt, input string db,
                                input int m, input int mm, input int go, input int ge);
      int h [0:LENGTH][0:63];
      int e [0:LENGTH][0:63];
      int f [0:LENGTH][0:63];
      int n, len, best, s, qb;
      n    = (cnt > LENGTH) ? LENGTH : cnt;
      len  = db.len();
      best = ZERO;
      for (int j = 0; j <= len; j++) begin h[0][j] = ZERO; e[0][j] = ZERO; end
      for (int i = 0; i <= n; i++)   begin h[i][0] = ZERO; f[i][0] = ZERO; end
      for (int i = 1; i <= n; i++) begin
         for (int j = 1; j <= len; j++) begin
            qb      = (i - 1 < q.len()) ? int'(code(q[i-1])) : 0;
            s       = (qb == int'(code(db[j-1]))) ? m : mm;
            e[i][j] = cl(mx(h[i-1][j] + go, e[i-1][j] + ge));
            f[i][j] = cl(mx(h[i][j-1] + go, f[i][j-1] + ge));
            h[i][j] = cl(mx(mx(h[i-1][j-1] + s, e[i][j]), f[i][j]));
            if (h[i][j] > best) best = h[i][j];
         end
      end
      return best;
   endfunction

   task automatic set_query(input string q);
      query = '0;
      for (int i = 0; i < q.len() && i < LENGTH; i++) query[2*i +: 2] = code(q[i]);
   endtask

   task automatic set_pen(input int m, input int mm, input int go, input int ge);
      t_match      = SW'(m);
      t_mismatch   = SW'(mm);
      t_gap_open   = SW'(go);
      t_gap_extend = SW'(ge);
   endtask

   task automatic add_vec(input string nm, input string q, input int cnt, input string db,
                          input int m, input int mm, input int go, input int ge, input int exp);
      vec_t v;
      v.name = nm; v.q = q; v.cnt = cnt; v.db = db;
      v.m = m; v.mm = mm; v.go = go; v.ge = ge; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Drives one sequence then one idle cycle; the expectation is queued with its vld cycle.
   task automatic drive_seq(input string db, input string nm, input int exp);
      sb_t s;
      for (int i = 0; i < db.len(); i++) begin
         @(negedge clk);
         en_in   = 1'b1;
         data_in = code(db[i]);
         if (i == db.len() - 1) begin
            s.name = nm;
            s.exp  = exp;
            s.cyc  = cyc + LENGTH + 2;
            sbq.push_back(s);
         end
      end
      @(negedge clk);
      en_in   = 1'b0;
      data_in = 2'b00;
   endtask

   task automatic drain();
      int w = 0;
      while (sbq.size() > 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (sbq.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic run_vec(input vec_t v);
      int exp;
      set_query(v.q);
      counter_in = 12'(v.cnt);
      set_pen(v.m, v.mm, v.go, v.ge);
      exp = (v.exp < 0) ? model(v.q, v.cnt, v.db, v.m, v.mm, v.go, v.ge) : v.exp;
      drive_seq(v.db, v.name, exp);
      drain();
   endtask

   // Scoreboard side: every vld pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (vld === 1'b1) begin
         vld_hist.push_back(cyc);
         if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_vld: vld=1 result=0x%0h at cycle %0d, expected no pulse",
                     result, cyc);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            check({e.name, "_result"}, int'(result), e.exp);
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int pulses;
      rst        = 1'b0;
      en_in      = 1'b0;
      data_in    = 2'b00;
      query      = '0;
      counter_in = 12'd0;
      set_pen(0, 0, 0, 0);

      add_vec("acgt_acgt",   "ACGT",          4, "ACGT",     5, -4, -12, -4, 'h814);
      add_vec("aaaa_tttt",   "AAAA",          4, "TTTT",     5, -4, -12, -4, 'h800);
      add_vec("one_gap",     "ACGTACGT",      8, "ACGACGT",  5, -4, -12, -4, 'h817);
      add_vec("tttt",        "ACGT",          4, "TTTT",     5, -4, -12, -4, 'h805);
      add_vec("single_base", "ACGT",          4, "G",        5, -4, -12, -4, 'h805);
      add_vec("cnt_zero",    "ACGT",          0, "ACGT",     5, -4, -12, -4, 'h800);
      add_vec("cnt_two",     "ACGT",          2, "ACGT",     5, -4, -12, -4, 'h80A);
      add_vec("cnt_two_gt",  "ACGT",          2, "GT",       5, -4, -12, -4, 'h800);
      add_vec("full_len",    rep("A", 48),  100, rep("A", 48), 5, -4, -12, -4, 'h8F0);
      add_vec("mismatch",    "ACGTTGCA",      8, "ACGTAGCA", 5, -4, -12, -4, 'h81F);
      add_vec("gap_extend",  "AAAACCCCGGGG", 12, "AAAAGGGG", 5, -4, -6,  -1, -1);
      add_vec("overflow",    rep("A", 30),   30, rep("A", 30), 100, -4, -12, -4, -1);
      add_vec("gattaca",     "GATTACA",       7, "TACGATTACAG", 3, -2, -5, -1, -1);

      repeat (3) begin
         @(negedge clk);
         check("rst_vld", int'(vld), 0);
         check("rst_result", int'(result), 'h800);
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_vld", int'(vld), 0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Two sequences with a single idle cycle between them.
      set_query("ACGT");
      counter_in = 12'd4;
      set_pen(5, -4, -12, -4);
      vld_hist.delete();
      drive_seq("ACGT", "b2b_first", 'h814);
      drive_seq("TTTT", "b2b_second", 'h805);
      drain();
      if (vld_hist.size() >= 2) check("b2b_gap", vld_hist[1] - vld_hist[0], 5);
      else                      check("b2b_gap", -1, 5);

      // Four sequences in flight at once.
      drive_seq("ACGT", "fl_acgt", 'h814);
      drive_seq("TTTT", "fl_tttt", 'h805);
      drive_seq("G",    "fl_g",    'h805);
      drive_seq("CGTA", "fl_cgta", model("ACGT", 4, "CGTA", 5, -4, -12, -4));
      drain();

      // Reset in the middle of a sequence: nothing may come out for it.
      foreach (vecs[i]) if (i == 0) begin end
      @(negedge clk);
      en_in = 1'b1; data_in = code("A");
      @(negedge clk);
      data_in = code("C");
      @(negedge clk);
      data_in = code("G");
      @(negedge clk);
      rst = 1'b0; en_in = 1'b0; data_in = 2'b00;
      @(negedge clk);
      check("abort_rst_vld", int'(vld), 0);
      check("abort_rst_result", int'(result), 'h800);
      @(negedge clk);
      rst    = 1'b1;
      pulses = 0;
      repeat (LENGTH + 6) begin
         @(negedge clk);
         if (vld === 1'b1) pulses++;
      end
      check("abort_no_vld", pulses, 0);
      drive_seq("ACGT", "after_abort", 'h814);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
